// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the natural-alignment test applied at request time.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_WAIT = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  // Accesses must be naturally aligned to their own size.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lo);
    case (size)
      SZ_H:    return lo[0];
      SZ_W:    return |lo[1:0];
      SZ_D:    return |lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobe/data placement into the doubleword and
// load extraction with sign or zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN/8,
  parameter int OFF_W  = $clog2(STRB_W)
) (
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [OFF_W-1:0]  off,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [STRB_W-1:0] wstrb,
  output logic [XLEN-1:0]   wdata_sh,
  output logic [XLEN-1:0]   ldata
);

  logic [STRB_W-1:0] base;
  logic [XLEN-1:0]   shifted;

  // Place store bytes at their lane, pull load bytes down and extend them.
  always_comb begin
    case (size)
      SZ_B:    base = STRB_W'(1);
      SZ_H:    base = STRB_W'(3);
      SZ_W:    base = STRB_W'(15);
      default: base = '1;
    endcase
    wstrb    = base << off;
    wdata_sh = wdata << {off, 3'b000};
    shifted  = rdata >> {off, 3'b000};
    // Doubleword loads have no extension, so the unsigned flag is moot there.
    case (size)
      SZ_B:    ldata = {{(XLEN-8){~uns & shifted[7]}},   shifted[7:0]};
      SZ_H:    ldata = {{(XLEN-16){~uns & shifted[15]}}, shifted[15:0]};
      SZ_W:    ldata = {{(XLEN-32){~uns & shifted[31]}}, shifted[31:0]};
      default: ldata = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one access from execute, traps
// misalignment locally, otherwise issues a single bus request and, for
// loads, waits for the decoupled response before pulsing done.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN/8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              done,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              misalign_exc,
  output logic [XLEN-1:0]   exc_addr,
  output logic              lsu_busy
);

  localparam int OFF_W = $clog2(STRB_W);

  logic [1:0]        state;
  logic              st_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [4:0]        rd_q;
  logic              exc_q;
  logic [4:0]        wb_rd_q;
  logic [XLEN-1:0]   wb_data_q;
  logic [XLEN-1:0]   exc_addr_q;
  logic [STRB_W-1:0] strb;
  logic [XLEN-1:0]   wdata_sh;
  logic [XLEN-1:0]   ldata;

  lsu_align #(.XLEN(XLEN), .STRB_W(STRB_W), .OFF_W(OFF_W)) u_align (
    .size     (size_q),
    .uns      (uns_q),
    .off      (addr_q[OFF_W-1:0]),
    .wdata    (wdata_q),
    .rdata    (mem_rdata),
    .wstrb    (strb),
    .wdata_sh (wdata_sh),
    .ldata    (ldata)
  );

  // All outputs decode from registered state, so bus fields stay stable
  // for as long as REQ is held.
  always_comb begin
    req_ready     = (state == ST_IDLE);
    lsu_busy      = (state != ST_IDLE);
    mem_req_valid = (state == ST_REQ);
    mem_we        = mem_req_valid & st_q;
    mem_addr      = {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    mem_wstrb     = st_q ? strb : '0;
    mem_wdata     = wdata_sh;
    done          = (state == ST_DONE);
    wb_we         = done & ~exc_q & ~st_q;
    misalign_exc  = done & exc_q;
    wb_rd         = wb_rd_q;
    wb_data       = wb_data_q;
    exc_addr      = exc_addr_q;
  end

  // Access FSM plus request latch and writeback result registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      st_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      exc_q      <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      exc_addr_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) begin
          st_q    <= req_store;
          size_q  <= req_size;
          uns_q   <= req_unsigned;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          rd_q    <= req_rd;
          // Misaligned accesses finish next cycle without any bus traffic.
          if (misaligned(req_size, req_addr[2:0])) begin
            exc_q      <= 1'b1;
            exc_addr_q <= req_addr;
            wb_rd_q    <= req_rd;
            state      <= ST_DONE;
          end else begin
            exc_q <= 1'b0;
            state <= ST_REQ;
          end
        end
        ST_REQ: if (mem_req_ready) state <= st_q ? ST_DONE : ST_WAIT;
        ST_WAIT: if (mem_rsp_valid) begin
          wb_data_q <= ldata;
          wb_rd_q   <= rd_q;
          state     <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a driver pushes expected completions and
// bus requests computed byte-by-byte from the access rules; a bus responder
// checks requests and inserts stalls; a monitor checks each done pulse.
module tb_lsu_ctrl;

  logic        sys_clk, sys_rst;
  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;
  logic        done, wb_we, misalign_exc, lsu_busy;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data, exc_addr;

  lsu_ctrl #(.XLEN(64), .STRB_W(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .done(done), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_exc(misalign_exc), .exc_addr(exc_addr), .lsu_busy(lsu_busy)
  );

  typedef struct {
    logic        st, exc;
    logic [4:0]  rd;
    logic [63:0] data, addr;
    int          acc, base;
  } exp_t;

  typedef struct {
    logic        we;
    logic [63:0] addr, wdata, rdata;
    logic [7:0]  strb;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, extra = 0;
  bit   mon_en = 0, resp_en = 0, rst_test = 0, prev_done = 0;
  int   stall_lo = 0, stall_hi = 0, dly_lo = 0, dly_hi = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Load result from first principles: gather n bytes, then extend.
  function automatic logic [63:0] exp_load(input logic [63:0] w, input int off,
                                            input int n, input logic uns);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
    if (!uns && n < 8 && v[8*n-1]) for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk_rst(input string tag);
    chk({tag, "_ctl"}, {57'd0, req_ready, lsu_busy, mem_req_valid, mem_we, done, wb_we, misalign_exc},
        64'b1000000);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_mem_wstrb"}, {56'd0, mem_wstrb}, 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({tag, "_wb_rd"}, {59'd0, wb_rd}, 64'd0);
    chk({tag, "_wb_data"}, wb_data, 64'd0);
    chk({tag, "_exc_addr"}, exc_addr, 64'd0);
  endtask

  task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input logic [4:0] rd, input logic [63:0] rdata);
    int n, off, g;
    exp_t e;
    bus_t b;
    g = 0;
    while (!req_ready && g < 500) begin @(negedge sys_clk); g++; end
    if (g >= 500) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1 within 500 cycles");
      return;
    end
    n = 1 << sz;
    off = int'(addr[2:0]);
    e.st = st; e.exc = (off % n) != 0; e.rd = rd; e.addr = addr; e.acc = cyc;
    e.data = exp_load(rdata, off, n, uns);
    e.base = e.exc ? 1 : (st ? 2 : 3);
    b.we = st; b.addr = addr - 64'(off); b.rdata = rdata; b.strb = '0;
    if (st) for (int i = 0; i < n; i++) b.strb[off+i] = 1'b1;
    b.wdata = wd << (8*off);
    extra = 0;
    exp_q.push_back(e);
    if (!e.exc) bus_q.push_back(b);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_rd = rd;
    @(negedge sys_clk);
    req_valid = 1'b0;
    req_store = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom}; req_rd = 5'($urandom);
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || !req_ready) && g < 300) begin @(negedge sys_clk); g++; end
    if (g >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d completions outstanding expected 0", exp_q.size());
    end
  endtask

  // Bus responder: checks every presented request, stalls, answers loads.
  int   stall_left = -1, dly_left = 0;
  bit   phase = 0;
  logic [63:0] rsp_word;
  bus_t rb;
  always @(negedge sys_clk) if (resp_en) begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    if (phase) begin
      if (dly_left > 0) begin dly_left--; extra++; end
      else begin mem_rsp_valid = 1'b1; mem_rdata = rsp_word; phase = 0; end
    end else if (mem_req_valid) begin
      if (bus_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL bus_unexpected: mem_req_valid 1 expected 0 (cycle %0d)", cyc);
      end else begin
        rb = bus_q[0];
        chk("mem_we", {63'd0, mem_we}, {63'd0, rb.we});
        chk("mem_addr", mem_addr, rb.addr);
        chk("mem_wstrb", {56'd0, mem_wstrb}, {56'd0, rb.strb});
        if (rb.we) chk("mem_wdata", mem_wdata, rb.wdata);
        if (stall_left < 0) stall_left = $urandom_range(stall_hi, stall_lo);
        if (stall_left > 0) begin stall_left--; extra++; end
        else begin
          mem_req_ready = 1'b1;
          stall_left = -1;
          void'(bus_q.pop_front());
          if (!rb.we) begin phase = 1; dly_left = $urandom_range(dly_hi, dly_lo); rsp_word = rb.rdata; end
        end
      end
    end else if ($urandom_range(0, 3) == 0) begin
      // Stray responses outside a load wait must be ignored.
      mem_rsp_valid = 1'b1;
      mem_rdata = {$urandom, $urandom};
    end
  end

  // Completion monitor.
  exp_t me;
  bit   exp_busy;
  always @(negedge sys_clk) if (mon_en) begin
    if (!rst_test) begin
      exp_busy = (exp_q.size() > 0) && (cyc > exp_q[0].acc);
      chk("lsu_busy", {63'd0, lsu_busy}, {63'd0, exp_busy});
      chk("req_ready", {63'd0, req_ready}, {63'd0, !exp_busy});
    end
    if (done) begin
      if (prev_done) begin
        checks++; errors++;
        $display("FAIL done_width: done high 2 cycles expected 1 (cycle %0d)", cyc);
      end
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: done 1 expected 0 (cycle %0d)", cyc);
      end else begin
        me = exp_q.pop_front();
        chk("latency", 64'(cyc - me.acc), 64'(me.base + extra));
        chk("wb_we", {63'd0, wb_we}, {63'd0, !me.exc && !me.st});
        chk("misalign_exc", {63'd0, misalign_exc}, {63'd0, me.exc});
        if (me.exc) chk("exc_addr", exc_addr, me.addr);
        if (!me.exc && !me.st) begin
          chk("wb_rd", {59'd0, wb_rd}, {59'd0, me.rd});
          chk("wb_data", wb_data, me.data);
        end
      end
    end else begin
      chk("flags_without_done", {62'd0, wb_we, misalign_exc}, 64'd0);
    end
    prev_done = done;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation still running after 60000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [63:0] a;
    sys_rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge sys_clk);
    chk_rst("reset");
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk_rst("post_reset");
    mon_en = 1; resp_en = 1;

    // Directed cases, bus never stalls.
    issue(1, 2'b00, 0, 64'h1003, 64'hAB, 5'd3, 64'h0);
    issue(0, 2'b01, 0, 64'h2006, 64'h0, 5'd9, 64'h8001_0000_0000_0000);
    issue(0, 2'b01, 1, 64'h2006, 64'h0, 5'd10, 64'h8001_0000_0000_0000);
    issue(1, 2'b10, 0, 64'h3002, 64'h1234_5678, 5'd4, 64'h0);
    issue(0, 2'b11, 1, 64'h2008, 64'h0, 5'd11, 64'hF123_4567_89AB_CDEF);
    drain();

    // Bus stalls 3 cycles, response arrives 2 cycles late.
    stall_lo = 3; stall_hi = 3; dly_lo = 2; dly_hi = 2;
    issue(0, 2'b10, 0, 64'h5004, 64'h0, 5'd17, 64'h8765_4321_0000_0000);
    issue(1, 2'b01, 0, 64'h5006, 64'hBEEF, 5'd18, 64'h0);
    drain();

    // Randomized traffic with random stalls and idle gaps.
    stall_lo = 0; stall_hi = 3; dly_lo = 0; dly_hi = 3;
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge sys_clk);
      sz = 2'($urandom);
      a = {32'd0, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~(64'(1 << sz) - 64'd1);
      issue(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom}, 5'($urandom),
            {$urandom, $urandom});
    end
    drain();

    // Reset while waiting on a load response; the late response is dropped.
    resp_en = 0; rst_test = 1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'b11; req_unsigned = 1'b0;
    req_addr = 64'h4000; req_rd = 5'd7;
    @(negedge sys_clk);
    req_valid = 1'b0;
    chk("rst_test_req", {63'd0, mem_req_valid}, 64'd1);
    chk("rst_test_addr", mem_addr, 64'h4000);
    mem_req_ready = 1'b1;
    @(negedge sys_clk);
    mem_req_ready = 1'b0;
    chk("rst_test_wait", {62'd0, lsu_busy, mem_req_valid}, 64'b10);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk_rst("rst_mid");
    mem_rsp_valid = 1'b1; mem_rdata = 64'hDEAD_BEEF_0123_4567;
    @(negedge sys_clk);
    mem_rsp_valid = 1'b0;
    chk_rst("rst_late_rsp");
    @(negedge sys_clk);
    chk_rst("rst_settled");
    rst_test = 0; resp_en = 1;

    issue(0, 2'b10, 1, 64'h6004, 64'h0, 5'd12, 64'hF0F0_1234_8765_4321);
    drain();
    repeat (2) @(negedge sys_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit sitting directly downstream of the execute stage: it takes the ALU-computed effective address plus store data/width from the decoder and performs one data-memory access over a valid/ready request bus with a decoupled response. Loads are shifted, sign- or zero-extended and returned as a single-cycle writeback pulse; stores complete on bus acceptance. Misaligned accesses are trapped without touching memory. `lsu_busy` stalls the upstream pipeline.

## Interface
Parameters:
- XLEN, 64, datapath and address width (matches the core's `` `width``).
- STRB_W, XLEN/8, byte-strobe width (8).

Ports:
- sys_clk  input  1  core clock; one clock domain, all state on rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- req_valid  input  1  execute stage presents an access.
- req_ready  output  1  high only in IDLE; transfer when req_valid && req_ready.
- req_store  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 double.
- req_unsigned  input  1  load zero-extends when 1.
- req_addr  input  XLEN  effective address (ALU result).
- req_wdata  input  XLEN  store data (rs2), low-order bytes significant.
- req_rd  input  5  load destination register.
- mem_req_valid  output  1  bus request.
- mem_req_ready  input  1  bus accepts request.
- mem_we  output  1  write request.
- mem_addr  output  XLEN  req_addr with bits [2:0] cleared.
- mem_wstrb  output  STRB_W  byte enables (stores only; 0 for loads).
- mem_wdata  output  XLEN  lane-shifted store data.
- mem_rsp_valid  input  1  load data valid.
- mem_rdata  input  XLEN  aligned 64-bit doubleword.
- done  output  1  one-cycle completion pulse (load, store or exception).
- wb_we  output  1  with done: register write required (loads only).
- wb_rd  output  5  destination register.
- wb_data  output  XLEN  extended load data.
- misalign_exc  output  1  with done: access was misaligned.
- exc_addr  output  XLEN  faulting address, valid with misalign_exc.
- lsu_busy  output  1  state != IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: on transfer, latch store/size/unsigned/addr/wdata/rd. Misaligned (half & addr[0]; word & addr[1:0]≠0; double & addr[2:0]≠0) -> DONE with exception flag; else -> REQ.
- REQ: mem_req_valid=1, bus fields stable from registers. On mem_req_ready: store -> DONE; load -> WAIT.
- WAIT: on mem_rsp_valid capture extended data -> DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Store lanes: off=addr[2:0]; mem_wstrb = ((1<<2^size)-1) << off; mem_wdata = req_wdata << 8*off.
- Load extract: shifted = mem_rdata >> 8*off; take low 2^size bytes; extend with bit (8·2^size−1) unless unsigned; double ignores unsigned.
- mem_rsp_valid outside WAIT is ignored. Exceptions: wb_we=0, no bus activity.

## Timing
- Reset: state IDLE; every output 0 except req_ready=1; latched registers 0.
- Store: accept cycle 0, mem_req_valid cycle 1 (ready same cycle), done cycle 2.
- Load: accept 0, REQ 1, earliest rsp 2, done 3. Each bus stall cycle adds one.
- Misaligned: accept 0, done 1.
- mem_req_valid held with stable fields until accepted (no retraction).
- Next request accepted no earlier than the cycle after done (req_ready rises in IDLE).
- Reset mid-operation: state forced IDLE immediately, no done; late response after reset ignored.
- wb_rd/wb_data/exc_addr hold until next done; only meaningful with done.

## Structure
- Package lsu_pkg: size encodings (SZ_B/H/W/D), FSM state enum, misalign function.
- Sub-module lsu_align: combinational strobe/wdata generation and load shift/extend; lsu_ctrl holds the FSM and registers.

## Test plan
- Store byte addr 0x1003 data 0xAB -> mem_addr 0x1000, wstrb 0x08, wdata[31:24]=0xAB, done cycle 2, wb_we=0.
- Load half signed addr 0x2006, mem_rdata 0x8001_0000_0000_0000 -> wb_data 0xFFFF_FFFF_FFFF_8001, wb_we=1, wb_rd echoed, done cycle 3.
- Same load with req_unsigned=1 -> wb_data 0x0000_0000_0000_8001.
- Word store addr 0x3002 -> misalign_exc=1, exc_addr 0x3002, done cycle 1, mem_req_valid never asserted.
- Load with mem_req_ready low 3 cycles, rsp 2 cycles later -> request fields stable throughout, done exactly one cycle, lsu_busy high until DONE exits.
- sys_rst during WAIT then rsp arrives -> no done, req_ready=1 next cycle, all outputs reset values.
